// File: rtl/sd_server_pkg.sv
// Shared types and constants for the SD sector server: sector geometry and the
// transfer state machine encoding.
package sd_server_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int IDX_W        = 9;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_PUT,
    WR_ADDR,
    WR_REQ,
    WR_WAIT,
    DONE
  } sd_srv_state_t;

endpackage

// File: rtl/sd_sector_server.sv
// Moves one 512-byte sector between the virtual SD card buffer and the
// SDRAM-resident disk image, one byte per memory access.
module sd_sector_server
  import sd_server_pkg::*;
#(
  parameter int                MEM_AW    = 23,
  parameter logic [MEM_AW-1:0] BASE_ADDR = 23'h400000,
  parameter logic [31:0]       MAX_LBA   = 32'd8191
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic              mem_ready
);

  sd_srv_state_t    state_q;
  logic             rdSync_q, rdPrev_q, wrSync_q, wrPrev_q;
  logic [31:0]      lba_q;
  logic [IDX_W-1:0] idx_q;
  logic             inRange_q;
  logic             ack_q;
  logic [7:0]       buffDout_q;
  logic             buffWr_q;
  logic [7:0]       memDout_q;
  logic             memRd_q, memWe_q;

  logic              rdEdge, wrEdge, lbaOk, lastByte;
  logic [MEM_AW-1:0] addrSum;

  assign rdEdge   = rdSync_q & ~rdPrev_q;
  assign wrEdge   = wrSync_q & ~wrPrev_q;
  assign lbaOk    = (sd_lba <= MAX_LBA);
  assign lastByte = (idx_q == IDX_W'(SECTOR_BYTES - 1));
  assign addrSum  = BASE_ADDR + MEM_AW'({lba_q, idx_q});

  // The address bus is held at zero outside a transfer so reset leaves every output low.
  assign mem_addr     = ack_q ? addrSum : '0;
  assign sd_ack       = ack_q;
  assign sd_buff_addr = idx_q;
  assign sd_buff_dout = buffDout_q;
  assign sd_buff_wr   = buffWr_q;
  assign mem_dout     = memDout_q;
  assign mem_rd       = memRd_q;
  assign mem_we       = memWe_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      rdSync_q   <= 1'b0;
      rdPrev_q   <= 1'b0;
      wrSync_q   <= 1'b0;
      wrPrev_q   <= 1'b0;
      lba_q      <= '0;
      idx_q      <= '0;
      inRange_q  <= 1'b0;
      ack_q      <= 1'b0;
      buffDout_q <= '0;
      buffWr_q   <= 1'b0;
      memDout_q  <= '0;
      memRd_q    <= 1'b0;
      memWe_q    <= 1'b0;
    end else begin
      rdSync_q <= sd_rd;
      rdPrev_q <= rdSync_q;
      wrSync_q <= sd_wr;
      wrPrev_q <= wrSync_q;
      memRd_q  <= 1'b0;
      memWe_q  <= 1'b0;
      buffWr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // A read edge wins over a simultaneous write edge; the write edge is lost.
          if (rdEdge || wrEdge) begin
            lba_q     <= sd_lba;
            idx_q     <= '0;
            inRange_q <= lbaOk;
            ack_q     <= 1'b1;
            if (rdEdge) begin
              memRd_q <= lbaOk;
              state_q <= RD_REQ;
            end else begin
              state_q <= WR_ADDR;
            end
          end
        end
        RD_REQ: begin
          if (inRange_q) begin
            state_q <= RD_WAIT;
          end else begin
            buffDout_q <= 8'h00;
            buffWr_q   <= 1'b1;
            state_q    <= RD_PUT;
          end
        end
        RD_WAIT: begin
          if (mem_ready) begin
            buffDout_q <= mem_din;
            buffWr_q   <= 1'b1;
            state_q    <= RD_PUT;
          end
        end
        RD_PUT: begin
          if (lastByte) begin
            ack_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            memRd_q <= inRange_q;
            state_q <= RD_REQ;
          end
        end
        WR_ADDR: begin
          memDout_q <= sd_buff_din;
          memWe_q   <= inRange_q;
          state_q   <= WR_REQ;
        end
        WR_REQ: begin
          if (inRange_q) begin
            state_q <= WR_WAIT;
          end else if (lastByte) begin
            ack_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= WR_ADDR;
          end
        end
        WR_WAIT: begin
          if (mem_ready) begin
            if (lastByte) begin
              ack_q   <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= WR_ADDR;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server: models the card buffer and a byte-wide
// memory with configurable ready latency, and checks each transfer scenario.
module tb_sd_sector_server;

  localparam int          MEM_AW = 23;
  localparam logic [22:0] BASE   = 23'h400000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic [22:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_rd, mem_we;
  logic        mem_ready;

  int vectors     = 0;
  int miscompares = 0;

  int bwCount, rdCount, weCount, overlapErr, latSum, pendLeft, ackCycles;
  bit outstanding, randLat, glitchReady, sawAck;
  logic [22:0] pendAddr;
  logic [8:0]  bwAddr [1024];
  logic [7:0]  bwData [1024];
  logic [22:0] rdLog  [1024];
  logic [22:0] weAddr [1024];
  logic [7:0]  weData [1024];
  logic [7:0]  cardBuf[512];

  always #5 clk_sys = ~clk_sys;

  sd_sector_server #(
    .MEM_AW   (MEM_AW),
    .BASE_ADDR(BASE),
    .MAX_LBA  (32'd8191)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_din (sd_buff_din),
    .sd_buff_wr  (sd_buff_wr),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .mem_din     (mem_din),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    bwCount = 0; rdCount = 0; weCount = 0; overlapErr = 0; latSum = 0;
  endtask

  // One clock: sample DUT just after the edge, log strobes, then drive the card
  // buffer and memory responses for the cycle that follows.
  task automatic applyStimulus();
    int lat;
    @(posedge clk_sys);
    #1;
    if (sd_buff_wr) begin
      if (bwCount < 1024) begin
        bwAddr[bwCount] = sd_buff_addr;
        bwData[bwCount] = sd_buff_dout;
      end
      bwCount++;
    end
    sd_buff_din = cardBuf[sd_buff_addr];
    mem_ready = 1'b0;
    if (mem_rd || mem_we) begin
      if (outstanding || (mem_rd && mem_we)) overlapErr++;
      lat = randLat ? int'($urandom_range(1, 7)) : 1;
      latSum += lat;
      outstanding = 1'b1;
      pendLeft = lat;
      pendAddr = mem_addr;
      if (mem_rd && rdCount < 1024) rdLog[rdCount] = mem_addr;
      if (mem_we && weCount < 1024) begin
        weAddr[weCount] = mem_addr;
        weData[weCount] = mem_dout;
      end
      if (mem_rd) rdCount++;
      if (mem_we) weCount++;
      if (glitchReady) begin
        mem_ready = 1'b1;
        mem_din = 8'h3C;
      end
    end else if (outstanding) begin
      pendLeft--;
      if (pendLeft == 0) begin
        mem_ready = 1'b1;
        mem_din = pendAddr[7:0] ^ 8'hA5;
        outstanding = 1'b0;
      end
    end
  endtask

  // Call right after raising a request line; measures how long sd_ack stays high.
  task automatic runTransfer(input string tag, input int dropAt, output int cycles);
    int guard;
    applyStimulus();
    checkOutput({tag, "_ack_cycle1"}, sd_ack, 0);
    applyStimulus();
    checkOutput({tag, "_ack_cycle2"}, sd_ack, 1);
    checkOutput({tag, "_idx0"}, sd_buff_addr, 0);
    cycles = 0;
    guard = 0;
    while (sd_ack === 1'b1 && guard < 6000) begin
      cycles++;
      if (cycles == dropAt) begin
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        sd_lba = 32'd5;
      end
      applyStimulus();
      guard++;
    end
  endtask

  task automatic holdCheck(input string tag, input int n);
    sawAck = 1'b0;
    repeat (n) begin
      applyStimulus();
      if (sd_ack) sawAck = 1'b1;
    end
    checkOutput(tag, sawAck, 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, sd_ack, 0);
    checkOutput({tag, "_buff_wr"}, sd_buff_wr, 0);
    checkOutput({tag, "_mem_rd"}, mem_rd, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_buff_addr"}, sd_buff_addr, 0);
    checkOutput({tag, "_buff_dout"}, sd_buff_dout, 0);
    checkOutput({tag, "_mem_dout"}, mem_dout, 0);
  endtask

  function automatic int badReadBytes(input bit zeroData);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (bwAddr[i] !== i[8:0]) bad++;
      else if (bwData[i] !== (zeroData ? 8'h00 : (i[7:0] ^ 8'hA5))) bad++;
    end
    return bad;
  endfunction

  function automatic int badReadAddrs(input logic [22:0] first);
    int bad = 0;
    for (int i = 0; i < 512; i++)
      if (rdLog[i] !== first + 23'(i)) bad++;
    return bad;
  endfunction

  function automatic int badWrites();
    int bad = 0;
    for (int i = 0; i < 512; i++)
      if (weAddr[i] !== BASE + 23'(i) || weData[i] !== 8'(i + 1)) bad++;
    return bad;
  endfunction

  initial begin
    int guard;
    reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
    sd_buff_din = '0; mem_din = '0; mem_ready = 1'b0;
    randLat = 1'b0; glitchReady = 1'b0; outstanding = 1'b0; pendLeft = 0;
    for (int i = 0; i < 512; i++) cardBuf[i] = 8'(i + 1);
    clearLogs();

    repeat (3) applyStimulus();
    checkIdleOutputs("reset");
    reset = 1'b0;
    repeat (2) applyStimulus();

    $display("[TB] read lba 3, request dropped and lba changed mid-transfer");
    clearLogs();
    sd_lba = 32'd3; sd_rd = 1'b1;
    runTransfer("rd", 300, ackCycles);
    checkOutput("rd_ack_cycles", ackCycles, 1536);
    checkOutput("rd_buff_wr_count", bwCount, 512);
    checkOutput("rd_bad_bytes", badReadBytes(1'b0), 0);
    checkOutput("rd_mem_rd_count", rdCount, 512);
    checkOutput("rd_bad_addrs", badReadAddrs(BASE + 23'h600), 0);
    checkOutput("rd_overlap", overlapErr, 0);

    $display("[TB] write lba 0 with random ready latency");
    clearLogs();
    randLat = 1'b1; glitchReady = 1'b1;
    sd_lba = 32'd0; sd_wr = 1'b1;
    runTransfer("wr", -1, ackCycles);
    checkOutput("wr_ack_cycles", ackCycles, 1024 + latSum);
    checkOutput("wr_mem_we_count", weCount, 512);
    checkOutput("wr_bad_writes", badWrites(), 0);
    checkOutput("wr_overlap", overlapErr, 0);
    checkOutput("wr_no_buff_wr", bwCount, 0);
    holdCheck("wr_held_no_retrigger", 10);
    randLat = 1'b0; glitchReady = 1'b0; sd_wr = 1'b0;
    applyStimulus();

    $display("[TB] out-of-range read and write");
    clearLogs();
    sd_lba = 32'd8192; sd_rd = 1'b1;
    runTransfer("oor_rd", -1, ackCycles);
    checkOutput("oor_rd_ack_cycles", ackCycles, 1024);
    checkOutput("oor_rd_mem_rd_count", rdCount, 0);
    checkOutput("oor_rd_buff_wr_count", bwCount, 512);
    checkOutput("oor_rd_bad_bytes", badReadBytes(1'b1), 0);
    sd_rd = 1'b0;
    applyStimulus();
    clearLogs();
    sd_wr = 1'b1;
    runTransfer("oor_wr", -1, ackCycles);
    checkOutput("oor_wr_ack_cycles", ackCycles, 1024);
    checkOutput("oor_wr_mem_we_count", weCount, 0);
    sd_wr = 1'b0;
    applyStimulus();

    $display("[TB] simultaneous read and write edges");
    clearLogs();
    sd_lba = 32'd3; sd_rd = 1'b1; sd_wr = 1'b1;
    runTransfer("both", -1, ackCycles);
    checkOutput("both_ack_cycles", ackCycles, 1536);
    checkOutput("both_mem_rd_count", rdCount, 512);
    checkOutput("both_mem_we_count", weCount, 0);
    checkOutput("both_bad_bytes", badReadBytes(1'b0), 0);
    holdCheck("both_held_no_retrigger", 20);

    $display("[TB] read retrigger at lba 8191, reset at byte 200");
    sd_rd = 1'b0;
    applyStimulus();
    clearLogs();
    sd_lba = 32'd8191; sd_rd = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("retrig_ack", sd_ack, 1);
    guard = 0;
    while (bwCount < 200 && guard < 2000) begin
      applyStimulus();
      guard++;
    end
    checkOutput("rst_reach_byte200", bwCount, 200);
    checkOutput("rst_first_addr", rdLog[0], 23'h7FFE00);
    reset = 1'b1;
    applyStimulus();
    checkIdleOutputs("mid_reset");
    applyStimulus();
    outstanding = 1'b0;
    mem_ready = 1'b0;
    clearLogs();
    reset = 1'b0;
    runTransfer("post_rst", -1, ackCycles);
    checkOutput("post_rst_ack_cycles", ackCycles, 1536);
    checkOutput("post_rst_buff_wr_count", bwCount, 512);
    checkOutput("post_rst_bad_bytes", badReadBytes(1'b0), 0);
    checkOutput("post_rst_bad_addrs", badReadAddrs(23'h7FFE00), 0);
    checkOutput("post_rst_overlap", overlapErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
